// File: rtl/l1_dcache_pkg.sv
// rtl/l1_dcache_pkg.sv - shared types, defaults and mask helper for the L1 data cache
package dcache_types;

    localparam int DEF_S_INDEX   = 3;
    localparam int DEF_LINE_BITS = 256;
    localparam int DEF_TAG_BITS  = 32 - 5 - DEF_S_INDEX;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESPOND   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } dcache_state_t;

    // Expands a word select plus 4 byte enables into a bit mask over the whole line.
    function automatic logic [DEF_LINE_BITS-1:0] line_be_mask(
        input logic [2:0] word_sel,
        input logic [3:0] byte_enable
    );
        logic [DEF_LINE_BITS-1:0] mask;
        mask = '0;
        for (int w = 0; w < DEF_LINE_BITS / 32; w++) begin
            for (int b = 0; b < 4; b++) begin
                mask[w*32 + b*8 +: 8] = {8{(word_sel == 3'(w)) && byte_enable[b]}};
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// rtl/l1_dcache_array.sv - tag/valid/dirty/data storage, async read and sync write
module dcache_array
    import dcache_types::*;
#(
    parameter int S_INDEX   = DEF_S_INDEX,
    parameter int TAG_BITS  = 32 - 5 - S_INDEX,
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_INDEX-1:0]     index,
    input  logic                   tag_we,
    input  logic [TAG_BITS-1:0]    tag_in,
    input  logic                   valid_in,
    input  logic                   dirty_we,
    input  logic                   dirty_in,
    input  logic                   data_we,
    input  logic [LINE_BITS/8-1:0] data_mask,
    input  logic [LINE_BITS-1:0]   data_in,
    output logic [TAG_BITS-1:0]    tag_out,
    output logic                   valid_out,
    output logic                   dirty_out,
    output logic [LINE_BITS-1:0]   data_out
);

    localparam int SETS = 1 << S_INDEX;

    logic [TAG_BITS-1:0]  tags [SETS];
    logic [LINE_BITS-1:0] lines [SETS];
    logic [SETS-1:0]      valid;
    logic [SETS-1:0]      dirty;

    // Only the state bits are reset; tag and data contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (tag_we)   valid[index] <= valid_in;
            if (dirty_we) dirty[index] <= dirty_in;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) tags[index] <= tag_in;
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int i = 0; i < LINE_BITS / 8; i++) begin
                if (data_mask[i]) lines[index][i*8 +: 8] <= data_in[i*8 +: 8];
            end
        end
    end

    assign tag_out   = tags[index];
    assign valid_out = valid[index];
    assign dirty_out = dirty[index];
    assign data_out  = lines[index];

endmodule

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - direct-mapped write-back write-allocate L1 data cache
module l1_dcache
    import dcache_types::*;
#(
    parameter int S_INDEX   = DEF_S_INDEX,
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_address,
    input  logic [31:0]          mem_wdata,
    output logic                 mem_resp,
    output logic [31:0]          mem_rdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int TAG_BITS = 32 - 5 - S_INDEX;
    localparam int WORDS    = LINE_BITS / 32;

    dcache_state_t state, state_next;
    logic          squash;
    logic          req_write;

    logic [TAG_BITS-1:0]  tag;
    logic [S_INDEX-1:0]   idx;
    logic [2:0]           wsel;
    logic [7:0]           wbase;
    logic                 req_valid;
    logic                 hit;

    logic                   arr_tag_we, arr_valid_in, arr_dirty_we, arr_dirty_in, arr_data_we;
    logic [LINE_BITS/8-1:0] arr_mask;
    logic [LINE_BITS-1:0]   arr_data_in;
    logic [TAG_BITS-1:0]    arr_tag;
    logic                   arr_valid, arr_dirty;
    logic [LINE_BITS-1:0]   arr_data;

    logic [LINE_BITS-1:0] be_mask;
    logic [LINE_BITS-1:0] fill_line;
    logic [1:0]           unused_addr_lsb;

    assign tag             = mem_address[31:5+S_INDEX];
    assign idx             = mem_address[4+S_INDEX:5];
    assign wsel            = mem_address[4:2];
    assign wbase           = {wsel, 5'b0};
    assign unused_addr_lsb = mem_address[1:0];

    assign req_valid = (mem_read || mem_write) && !flush;
    assign hit       = arr_valid && (arr_tag == tag);

    // A store that missed is folded into the fill data so install and merge share one edge.
    assign be_mask   = line_be_mask(wsel, mem_byte_enable);
    assign fill_line = req_write ? ((pmem_rdata & ~be_mask) | ({WORDS{mem_wdata}} & be_mask))
                                 : pmem_rdata;

    dcache_array #(
        .S_INDEX   (S_INDEX),
        .TAG_BITS  (TAG_BITS),
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (idx),
        .tag_we    (arr_tag_we),
        .tag_in    (tag),
        .valid_in  (arr_valid_in),
        .dirty_we  (arr_dirty_we),
        .dirty_in  (arr_dirty_in),
        .data_we   (arr_data_we),
        .data_mask (arr_mask),
        .data_in   (arr_data_in),
        .tag_out   (arr_tag),
        .valid_out (arr_valid),
        .dirty_out (arr_dirty),
        .data_out  (arr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (hit)                        state_next = RESPOND;
                    else if (arr_valid && arr_dirty) state_next = WRITEBACK;
                    else                            state_next = FILL;
                end
            end
            WRITEBACK: if (pmem_resp) state_next = FILL;
            FILL:      if (pmem_resp) state_next = RESPOND;
            RESPOND:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        arr_tag_we   = 1'b0;
        arr_valid_in = 1'b0;
        arr_dirty_we = 1'b0;
        arr_dirty_in = 1'b0;
        arr_data_we  = 1'b0;
        arr_mask     = '0;
        arr_data_in  = '0;
        case (state)
            IDLE: begin
                if (req_valid && hit && mem_write) begin
                    arr_data_we  = 1'b1;
                    arr_mask     = (LINE_BITS/8)'(mem_byte_enable) << {wsel, 2'b0};
                    arr_data_in  = {WORDS{mem_wdata}};
                    arr_dirty_we = 1'b1;
                    arr_dirty_in = 1'b1;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {arr_tag, idx, 5'b0};
                pmem_wdata   = arr_data;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag, idx, 5'b0};
                if (pmem_resp) begin
                    arr_tag_we   = 1'b1;
                    arr_valid_in = 1'b1;
                    arr_data_we  = 1'b1;
                    arr_mask     = '1;
                    arr_data_in  = fill_line;
                    arr_dirty_we = 1'b1;
                    arr_dirty_in = req_write;
                end
            end
            RESPOND: mem_resp = !(squash && !req_write);
            default: ;
        endcase
        // A reset landing on the fill edge must not leave a half-installed line behind.
        if (rst) begin
            arr_tag_we   = 1'b0;
            arr_dirty_we = 1'b0;
            arr_data_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata <= '0;
            squash    <= 1'b0;
            req_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_write <= mem_write;
                        if (hit && !mem_write) mem_rdata <= arr_data[wbase +: 32];
                    end
                end
                WRITEBACK: begin
                    if (flush && !req_write) squash <= 1'b1;
                end
                FILL: begin
                    if (flush && !req_write) squash <= 1'b1;
                    if (pmem_resp) mem_rdata <= fill_line[wbase +: 32];
                end
                RESPOND: squash <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
